// File: rtl/mioc_pkg.sv
// Shared constants for the memory/IO access scheduler: FSM encoding and fixed IO values.
package mioc_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEM_RD  = 2'd1;
  localparam logic [1:0] ST_IO_WAIT = 2'd2;

  localparam logic [31:0] IO_BASE     = 32'hFFFF_F000;
  localparam logic [31:0] IO_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mioc_wait_cnt.sv
// Loadable down-counter; times both the RAM read latency and the IO wait limit.
module mioc_wait_cnt
  import mioc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst)
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);

  assign zero = (cnt == '0);
endmodule

// File: rtl/mioc_sched.sv
// Memory/IO scheduler: arbitrates data vs fetch onto the shared RAM and IO bus.
// Optional IO timeout (io_err port) is enabled by defining MIOC_TIMEOUT_EN.
module mioc_sched
  import mioc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MEM_LAT     = 1,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_mr,
  input  logic              d_mw,
  input  logic              d_io_r,
  input  logic              d_io_w,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_rd,
  output logic              io_wr,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
`ifdef MIOC_TIMEOUT_EN
  , output logic            io_err
`endif
);
  localparam int CNT_MAX = (TIMEOUT_CYC > MEM_LAT) ? TIMEOUT_CYC : MEM_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SC_W    = $clog2(STARVE_MAX + 1);

  logic [1:0]       state, nxt;
  logic             owner_i, io_rd_q;
  logic [31:0]      io_addr_q, io_wdata_q;
  logic [SC_W-1:0]  starve_cnt;
  logic             grant_i, grant_d, d_done, i_done;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             d_req, d_io;
  logic             unused_ok;

  assign d_req     = d_mr | d_mw | d_io_r | d_io_w;
  assign d_io      = d_io_r | d_io_w;
  assign unused_ok = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};

  mioc_wait_cnt #(.W(CNT_W)) u_wait (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val(cnt_val),
    .dec(cnt_dec), .zero(cnt_zero)
  );

  always_comb begin
    nxt = state;
    grant_i = 1'b0; grant_d = 1'b0; d_done = 1'b0; i_done = 1'b0;
    cnt_load = 1'b0; cnt_val = '0; cnt_dec = 1'b0;
    ram_en = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0;
    io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    d_rdata = '0; i_rdata = '0;
`ifdef MIOC_TIMEOUT_EN
    io_err = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (i_req && (!d_req || starve_cnt == SC_W'(STARVE_MAX))) begin
          grant_i = 1'b1; ram_en = 1'b1; ram_addr = i_addr[ADDR_W+1:2];
          cnt_load = 1'b1; cnt_val = CNT_W'(MEM_LAT - 1); nxt = ST_MEM_RD;
        end else if (d_req) begin
          grant_d = 1'b1;
          if (d_io) begin
            // read wins when both IO strobes are set
            io_rd = d_io_r; io_wr = !d_io_r; io_addr = d_addr; io_wdata = d_wdata;
            if (io_ack) begin
              d_done = 1'b1; d_rdata = io_rdata;
            end else begin
              cnt_load = 1'b1; cnt_val = CNT_W'(TIMEOUT_CYC - 1); nxt = ST_IO_WAIT;
            end
          end else begin
            ram_en = 1'b1; ram_addr = d_addr[ADDR_W+1:2];
            if (d_mr) begin
              cnt_load = 1'b1; cnt_val = CNT_W'(MEM_LAT - 1); nxt = ST_MEM_RD;
            end else begin
              ram_we = 1'b1; ram_wdata = d_wdata; d_done = 1'b1;
            end
          end
        end
      end
      ST_MEM_RD: begin
        if (cnt_zero) begin
          nxt = ST_IDLE;
          if (owner_i) begin i_done = 1'b1; i_rdata = ram_rdata; end
          else         begin d_done = 1'b1; d_rdata = ram_rdata; end
        end else cnt_dec = 1'b1;
      end
      ST_IO_WAIT: begin
        io_rd = io_rd_q; io_wr = !io_rd_q; io_addr = io_addr_q; io_wdata = io_wdata_q;
        if (io_ack) begin
          d_done = 1'b1; d_rdata = io_rdata; nxt = ST_IDLE;
        end
`ifdef MIOC_TIMEOUT_EN
        else if (cnt_zero) begin
          io_rd = 1'b0; io_wr = 1'b0; io_err = 1'b1;
          d_rdata = IO_ERR_DATA; d_done = 1'b1; nxt = ST_IDLE;
        end else cnt_dec = 1'b1;
`endif
      end
      default: nxt = ST_IDLE;
    endcase
    d_stall = d_req & ~d_done;
    i_stall = i_req & ~i_done;
    // reset forces every output low at once, including a held IO strobe
    if (!rst) begin
      d_rdata = '0; d_stall = 1'b0; i_rdata = '0; i_stall = 1'b0;
      ram_en = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0;
      io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
`ifdef MIOC_TIMEOUT_EN
      io_err = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE; owner_i <= 1'b0; io_rd_q <= 1'b0;
      io_addr_q <= '0; io_wdata_q <= '0; starve_cnt <= '0;
    end else begin
      state <= nxt;
      if (grant_i)      owner_i <= 1'b1;
      else if (grant_d) owner_i <= 1'b0;
      if (grant_d && d_io) begin
        io_rd_q <= d_io_r; io_addr_q <= d_addr; io_wdata_q <= d_wdata;
      end
      if (!i_req || grant_i) starve_cnt <= '0;
      else if (grant_d)      starve_cnt <= starve_cnt + SC_W'(1);
    end
endmodule
